min_tree_blk_cbfp: RTL
======================

// Module: min_tree_blk_cbfp
// PURPOSE
//  Parametrised, fully pipelined min-reduction tree for CBFP exponent detection.
//  - Per beat: takes NUM_IN leading-zero counts and returns their minimum and the winning lane index.
//  - Per block: accumulates a running minimum over BLK_LEN beats, giving the block exponent.
//  - Sits between the per-sample LZC units and the CBFP shifter in each FFT stage.
// PARAMETERS
//  LZC_WIDTH  5   bit width of each leading-zero count
//  NUM_IN     16  lanes per beat; power of two, >= 2
//  BLK_LEN    4   beats per CBFP block; >= 1
//  (derived) LVL = $clog2(NUM_IN), IDX_W = LVL, CNT_W = $clog2(BLK_LEN)+1
// PORTS
//  clk         in   1                  system clock, rising edge
//  rst         in   1                  asynchronous reset, active-high
//  en          in   1                  global advance; 0 freezes every register
//  in_valid    in   1                  min_in holds a valid beat
//  min_in      in   LZC_WIDTH x NUM_IN unpacked array [0:NUM_IN-1] of LZC values
//  blk_clr     in   1                  synchronous abort of the partial block
//  beat_valid  out  1                  beat_min/beat_idx valid
//  beat_min    out  LZC_WIDTH          minimum of one beat
//  beat_idx    out  IDX_W              lowest lane index holding beat_min
//  blk_valid   out  1                  blk_min updated; lasts one enabled cycle
//  blk_min     out  LZC_WIDTH          minimum over the last complete block
// BEHAVIOUR
//  Reset
//  - rst=1 clears asynchronously: all pipeline data/valid regs, the beat counter, the accumulator and every output.
//  - Reset value of every output is 0.
//  Tree
//  - LVL levels of 2-input compare nodes, with a register after each level.
//  - Each register holds {min, idx, valid}.
//  - Latency: LVL enabled cycles from in_valid sampled to beat_valid. Default LVL=4.
//  - Node rule: choose a if a <= b, else b. On a tie the lower lane wins.
//  - idx grows 1 bit per level as {sel_b, child_idx}.
//  - Full throughput: one beat per enabled cycle. No backpressure.
//  en
//  - en=0: all regs hold, and in_valid/min_in are ignored that cycle.
//  - Beats are never lost or duplicated across stalls.
//  Block accumulator (acts on beat_valid while en=1)
//  - cnt==0: acc <= beat_min, cnt <= 1.
//  - Otherwise: acc <= min(acc, beat_min), cnt <= cnt+1.
//  - When the beat arrives with cnt==BLK_LEN-1:
//    - next cycle: blk_min <= min(acc, beat_min) and blk_valid <= 1.
//    - cnt wraps to 0.
//  - BLK_LEN=1: every beat produces blk_valid.
//  - blk_valid clears on the next enabled cycle unless another block completes.
//  - blk_valid holds while en=0.
//  - blk_min holds its value until the next block completes.
//  blk_clr
//  - Takes effect regardless of en. Sets cnt=0 and discards acc.
//  - blk_clr together with an accepted beat: that beat starts a new block (acc=beat, cnt=1).
//  - blk_clr together with a completing beat: the block still completes (blk_valid=1) and cnt=0.
//  - Beats already in the tree are unaffected.
//  Widths
//  - Compares are unsigned LZC_WIDTH. No arithmetic growth.
//  - cnt is CNT_W bits and never exceeds BLK_LEN-1.
//  Reset mid-operation
//  - In-flight beats and any partial block are dropped.
//  - The first beat after reset is beat 1 of a new block.
// TESTING
//  1. NUM_IN=16, en=1, one beat min_in[k]=20-k except min_in[9]=3
//     -> 4 cycles later beat_valid=1, beat_min=3, beat_idx=9.
//  2. Ties:
//     - all lanes=7 -> beat_min=7, beat_idx=0.
//     - lanes 5 and 12 =2, rest 9 -> beat_min=2, beat_idx=5.
//  3. BLK_LEN=4, four back-to-back beats with mins 10,4,8,6
//     -> blk_valid high 1 cycle after the 4th beat_valid, blk_min=4.
//     -> then a block of 12,12,12,12 -> blk_min=12.
//  4. Stream 8 beats with en=0 for 3 cycles mid-stream
//     -> exactly 8 beat_valid, in order, with values unchanged.
//     -> blk_valid held through the stall and 2 blocks reported.
//  5. 2 beats (min 1,1), blk_clr, then 4 beats (5,3,7,6)
//     -> a single blk_valid with blk_min=3.
//  6. rst pulse after 2 beats of a block
//     -> all outputs 0 immediately.
//     -> the next 4 beats (9,2,4,8) -> blk_min=2.

Source files
------------

// File: rtl/min_tree_blk_cbfp_if.sv
// Beat/block bus for the CBFP min-reduction tree: lane LZC inputs, control, and results.
interface min_tree_blk_cbfp_if #(
  parameter int LZC_WIDTH = 5,
  parameter int NUM_IN    = 16
);
  localparam int IDX_W = $clog2(NUM_IN);

  logic                 en;
  logic                 in_valid;
  logic [LZC_WIDTH-1:0] min_in [0:NUM_IN-1];
  logic                 blk_clr;
  logic                 beat_valid;
  logic [LZC_WIDTH-1:0] beat_min;
  logic [IDX_W-1:0]     beat_idx;
  logic                 blk_valid;
  logic [LZC_WIDTH-1:0] blk_min;

  modport master (
    output en, in_valid, min_in, blk_clr,
    input  beat_valid, beat_min, beat_idx, blk_valid, blk_min
  );

  modport slave (
    input  en, in_valid, min_in, blk_clr,
    output beat_valid, beat_min, beat_idx, blk_valid, blk_min
  );
endinterface

// File: rtl/min_tree_blk_cbfp.sv
// Pipelined min-reduction tree over NUM_IN lane LZCs with a per-block running minimum
// that yields the CBFP block exponent.
module min_tree_blk_cbfp #(
  parameter int LZC_WIDTH = 5,
  parameter int NUM_IN    = 16,
  parameter int BLK_LEN   = 4
) (
  input logic              clk,
  input logic              rst,
  min_tree_blk_cbfp_if.slave io
);
  localparam int LVL   = $clog2(NUM_IN);
  localparam int IDX_W = LVL;
  localparam int CNT_W = $clog2(BLK_LEN) + 1;
  localparam int NODES = NUM_IN - 1;
  localparam int SRCS  = 2 * NUM_IN - 1;

  // Flat node store: sources 0..NUM_IN-1 are the lanes, NUM_IN+k is tree register k.
  // Stage s (0 = lanes) starts at source index 2*NUM_IN - 2*(NUM_IN >> s).
  function automatic int unsigned stage_base(input int unsigned s);
    return 2 * NUM_IN - 2 * (NUM_IN >> s);
  endfunction

  logic [LZC_WIDTH-1:0] nd_min  [NODES];
  logic [IDX_W-1:0]     nd_idx  [NODES];
  logic [LVL-1:0]       nd_vld;
  logic [LZC_WIDTH-1:0] nxt_min [NODES];
  logic [IDX_W-1:0]     nxt_idx [NODES];
  logic [LZC_WIDTH-1:0] src_min [SRCS];
  logic [IDX_W-1:0]     src_idx [SRCS];

  always_comb begin
    for (int unsigned j = 0; j < NUM_IN; j++) begin
      src_min[j] = io.min_in[j];
      src_idx[j] = IDX_W'(j);
    end
    for (int unsigned k = 0; k < NODES; k++) begin
      src_min[NUM_IN + k] = nd_min[k];
      src_idx[NUM_IN + k] = nd_idx[k];
    end
  end

  // Indices carry absolute lane numbers, so picking a child's idx equals {sel_b, child_idx}.
  always_comb begin
    for (int unsigned k = 0; k < NODES; k++) begin
      nxt_min[k] = '0;
      nxt_idx[k] = '0;
    end
    for (int unsigned s = 1; s <= LVL; s++) begin
      for (int unsigned j = 0; j < (NUM_IN >> s); j++) begin
        if (src_min[stage_base(s - 1) + 2 * j + 1] < src_min[stage_base(s - 1) + 2 * j]) begin
          nxt_min[stage_base(s) - NUM_IN + j] = src_min[stage_base(s - 1) + 2 * j + 1];
          nxt_idx[stage_base(s) - NUM_IN + j] = src_idx[stage_base(s - 1) + 2 * j + 1];
        end else begin
          nxt_min[stage_base(s) - NUM_IN + j] = src_min[stage_base(s - 1) + 2 * j];
          nxt_idx[stage_base(s) - NUM_IN + j] = src_idx[stage_base(s - 1) + 2 * j];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned k = 0; k < NODES; k++) begin
        nd_min[k] <= '0;
        nd_idx[k] <= '0;
      end
      nd_vld <= '0;
    end else if (io.en) begin
      for (int unsigned k = 0; k < NODES; k++) begin
        nd_min[k] <= nxt_min[k];
        nd_idx[k] <= nxt_idx[k];
      end
      nd_vld[0] <= io.in_valid;
      for (int unsigned s = 1; s < LVL; s++) begin
        nd_vld[s] <= nd_vld[s - 1];
      end
    end
  end

  assign io.beat_valid = nd_vld[LVL - 1];
  assign io.beat_min   = nd_min[NODES - 1];
  assign io.beat_idx   = nd_idx[NODES - 1];

  logic [CNT_W-1:0]     cnt;
  logic [LZC_WIDTH-1:0] acc;
  logic [LZC_WIDTH-1:0] run_min;
  logic                 last_beat;
  logic                 blk_valid;
  logic [LZC_WIDTH-1:0] blk_min;

  always_comb begin
    run_min = io.beat_min;
    if ((cnt != '0) && (acc < io.beat_min)) begin
      run_min = acc;
    end
    last_beat = (cnt == CNT_W'(BLK_LEN - 1));
  end

  // Completion outranks blk_clr; otherwise blk_clr restarts the block, even while stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      acc       <= '0;
      blk_valid <= 1'b0;
      blk_min   <= '0;
    end else if (io.en) begin
      blk_valid <= 1'b0;
      if (io.beat_valid) begin
        if (last_beat) begin
          blk_min   <= run_min;
          blk_valid <= 1'b1;
          cnt       <= '0;
        end else if (io.blk_clr || (cnt == '0)) begin
          acc <= io.beat_min;
          cnt <= CNT_W'(1);
        end else begin
          acc <= run_min;
          cnt <= cnt + 1'b1;
        end
      end else if (io.blk_clr) begin
        cnt <= '0;
        acc <= '0;
      end
    end else if (io.blk_clr) begin
      cnt <= '0;
      acc <= '0;
    end
  end

  assign io.blk_valid = blk_valid;
  assign io.blk_min   = blk_min;
endmodule
